result_drain_ctrl: RTL and testbench
====================================

RESULT_DRAIN_CTRL -- requirements
Module: result_drain_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDRESSSIZE, 10, results-SRAM address width.
- MATRIX_SIZE, 64, lanes per result row.
- PARTIAL_SUM_BW, 24, bits per lane.
- DATA_BW, 8, bits per requantized lane.
REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
- clk  in  1  sole clock; all logic is rising-edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  single-cycle drain request.
- base_addr  in  ADDRESSSIZE  first row address.
- num_rows  in  7  rows to drain, 0..64.
- shift  in  5  requantize right-shift amount.
- sram_re  out  1  results-SRAM read strobe.
- sram_addr  out  ADDRESSSIZE  read address.
- sram_rdata  in  PARTIAL_SUM_BW*MATRIX_SIZE  read data, valid the cycle after sram_re.
- m_valid  out  1  output row valid.
- m_ready  in  1  sink accepts the row.
- m_data  out  OW  row payload; OW is defined under Configuration.
- m_last  out  1  marks the final row.
- busy  out  1  drain in progress.
- done  out  1  one-cycle completion pulse.

Function
REQ-003 The FSM SHALL have states IDLE, READ, DRAIN and FIN.
REQ-004 IDLE transitions:
- start with num_rows>0 moves to READ and latches base_addr, num_rows and shift.
- start with num_rows=0 moves to FIN and issues no reads.
REQ-005 READ SHALL assert sram_re for exactly num_rows cycles in total, at addresses base_addr+i for i=0..num_rows-1, taken modulo 2^ADDRESSSIZE.
REQ-006 Read issue SHALL be credit-gated: a read issues only when (buffer occupancy + reads in flight − pop this cycle) < 2.
REQ-007 Returned rows SHALL enter a 2-entry FIFO in issue order; no row is dropped or duplicated.
REQ-008 The last read moves READ to DRAIN; DRAIN moves to FIN once the last row has been handshaken.
REQ-009 FIN SHALL assert done for exactly one cycle, then return to IDLE.
REQ-010 busy SHALL be 1 in READ, DRAIN and FIN, and 0 in IDLE.
REQ-011 Latency: with start sampled at edge T, the first sram_re SHALL be in cycle T+1 and the first m_valid in cycle T+3.
REQ-012 With m_ready held at 1, the block SHALL deliver one row per cycle with no bubbles.
REQ-013 Handshake rules:
- A transfer occurs when m_valid and m_ready are both 1.
- While m_valid=1 and m_ready=0, m_data and m_last SHALL hold stable.
- m_valid SHALL NOT fall without a transfer.
REQ-014 m_last SHALL be 1 only on row num_rows-1.
REQ-015 start while busy=1 SHALL be ignored, with no effect on the latched parameters.
REQ-016 When a pop and a push occur in the same cycle on a full FIFO, the FIFO SHALL keep correct order and count.

Reset
REQ-017 rstn low SHALL asynchronously force state IDLE, FIFO empty and the in-flight count to 0.
REQ-018 While rstn is low, all outputs SHALL be 0: sram_re, sram_addr, m_valid, m_data, m_last, busy and done.
REQ-019 Reset mid-drain SHALL discard all buffered and in-flight rows, and done SHALL NOT pulse for the aborted drain.

Configuration
REQ-020 With RESULT_DRAIN_REQUANT_EN defined:
- OW = DATA_BW*MATRIX_SIZE.
- Each signed lane is arithmetically shifted right by the latched shift, then saturated to [-128,127].
- This logic is combinational on the FIFO output and adds no latency.
REQ-021 Without RESULT_DRAIN_REQUANT_EN:
- OW = PARTIAL_SUM_BW*MATRIX_SIZE.
- Lanes pass unmodified.
- The shift port SHALL be present but ignored.

Structure
REQ-022 FSM state encodings, the FIFO depth constant (2) and the lane-width constants SHALL live in the shared tpu_params_pkg.
REQ-023 The 2-entry FIFO SHALL be a separate sub-module, result_skid_fifo, with push/pop/full/empty/count ports.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- base_addr=0, num_rows=64, m_ready=1 -> sram_re in cycles T+1..T+64; 64 rows on m_valid in T+3..T+66, in address order; m_last in T+66; done in T+67.
- num_rows=4, m_ready toggling 1,0,0,1 -> at most 2 reads ahead of the sink; m_data stable through the stalls; exactly 4 transfers; done once.
- base_addr=1022, num_rows=4 -> addresses 1022, 1023, 0, 1.
- num_rows=0 -> no sram_re; done pulses at T+1; busy is high for exactly that one cycle.
- rstn pulled low after 10 of 64 rows -> all outputs 0 immediately; no done pulse; a new start then drains correctly.
- REQUANT_EN, lane = 24'h00_1234, shift=4 -> 8'h7F (saturated).
- REQUANT_EN, lane = -300, shift=1 -> -128.
- REQUANT_EN, lane = 200, shift=2 -> 50.

Source files
------------

// File: rtl/tpu_params_pkg.sv
// Shared constants for the TPU result path: drain FSM encoding, skid FIFO depth and lane widths.
package tpu_params_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } drain_state_t;

    localparam int FIFO_DEPTH   = 2;
    localparam int FIFO_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int FIFO_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LANE_PSUM_BW = 24;
    localparam int LANE_DATA_BW = 8;
    localparam int ROWS_W       = 7;
    localparam int SHIFT_W      = 5;
endpackage

// File: rtl/result_skid_fifo.sv
// Two-entry FIFO buffering returned SRAM rows; zero-latency read of the head entry.
// A push while full is accepted only together with a pop, so order and count stay exact.
module result_skid_fifo
    import tpu_params_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [W-1:0]          wdata,
    input  logic                  pop,
    output logic [W-1:0]          rdata,
    output logic                  full,
    output logic                  empty,
    output logic [FIFO_CNT_W-1:0] count
);
    logic [W-1:0]          r_mem [FIFO_DEPTH];
    logic [FIFO_PTR_W-1:0] r_wptr;
    logic [FIFO_PTR_W-1:0] r_rptr;
    logic [FIFO_CNT_W-1:0] r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == FIFO_CNT_W'(FIFO_DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rdata     = r_mem[r_rptr];
    assign w_do_pop  = pop & ~empty;
    // When full, the slot being written is the head being popped this same cycle.
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= wdata;
                r_wptr        <= r_wptr + FIFO_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + FIFO_PTR_W'(1);
            end
            r_count <= r_count + FIFO_CNT_W'(w_do_push) - FIFO_CNT_W'(w_do_pop);
        end
    end
endmodule

// File: rtl/result_drain_ctrl.sv
// Drains num_rows result rows from SRAM to a valid/ready sink; first read 1 cycle, first row 3 cycles after start.
// Reads are credit-gated against the 2-entry skid FIFO; RESULT_DRAIN_REQUANT_EN adds combinational shift+saturate to int8.
module result_drain_ctrl
    import tpu_params_pkg::*;
#(
    parameter int ADDRESSSIZE    = 10,
    parameter int MATRIX_SIZE    = 64,
    parameter int PARTIAL_SUM_BW = LANE_PSUM_BW,
    parameter int DATA_BW        = LANE_DATA_BW,
`ifdef RESULT_DRAIN_REQUANT_EN
    localparam int OW = DATA_BW * MATRIX_SIZE
`else
    localparam int OW = PARTIAL_SUM_BW * MATRIX_SIZE
`endif
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                start,
    input  logic [ADDRESSSIZE-1:0]              base_addr,
    input  logic [ROWS_W-1:0]                   num_rows,
    input  logic [SHIFT_W-1:0]                  shift,
    output logic                                sram_re,
    output logic [ADDRESSSIZE-1:0]              sram_addr,
    input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] sram_rdata,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [OW-1:0]                       m_data,
    output logic                                m_last,
    output logic                                busy,
    output logic                                done
);
    localparam int RW = PARTIAL_SUM_BW * MATRIX_SIZE;

    drain_state_t           r_state;
    drain_state_t           w_next;
    logic [ADDRESSSIZE-1:0] r_base;
    logic [ROWS_W-1:0]      r_rows;
    logic [ROWS_W-1:0]      r_issued;
    logic [ROWS_W-1:0]      r_popped;
    logic                   r_inflight;
    logic                   w_re;
    logic                   w_pop;
    logic                   w_valid;
    logic                   w_credit_ok;
    logic                   w_last_rd;
    logic                   w_last_row;
    logic [RW-1:0]          w_head;
    logic                   w_fifo_empty;
    logic                   w_fifo_full_unused;
    logic [FIFO_CNT_W-1:0]  w_fifo_count;
    logic [OW-1:0]          w_out;

    // Occupancy plus the read already in flight must leave room once this cycle's pop is credited.
    assign w_credit_ok = (3'(w_fifo_count) + 3'(r_inflight)) < (3'(FIFO_DEPTH) + 3'(w_pop));
    assign w_last_rd   = (r_issued == r_rows - ROWS_W'(1));
    assign w_last_row  = (r_popped == r_rows - ROWS_W'(1));
    assign w_valid     = ~w_fifo_empty;
    assign w_pop       = w_valid & m_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_re   = 1'b0;
        busy   = 1'b1;
        done   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = (num_rows == '0) ? ST_FIN : ST_READ;
                end
            end
            ST_READ: begin
                w_re = w_credit_ok;
                if (w_credit_ok && w_last_rd) begin
                    w_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_last_row) begin
                    w_next = ST_FIN;
                end
            end
            ST_FIN: begin
                done   = 1'b1;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_base     <= '0;
            r_rows     <= '0;
            r_issued   <= '0;
            r_popped   <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_re;
            if (r_state == ST_IDLE && start) begin
                r_base   <= base_addr;
                r_rows   <= num_rows;
                r_issued <= '0;
                r_popped <= '0;
            end else begin
                if (w_re) begin
                    r_issued <= r_issued + ROWS_W'(1);
                end
                if (w_pop) begin
                    r_popped <= r_popped + ROWS_W'(1);
                end
            end
        end
    end

    assign sram_re   = w_re;
    assign sram_addr = w_re ? (r_base + ADDRESSSIZE'(r_issued)) : '0;

    result_skid_fifo #(
        .W (RW)
    ) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (r_inflight),
        .wdata (sram_rdata),
        .pop   (w_pop),
        .rdata (w_head),
        .full  (w_fifo_full_unused),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

`ifdef RESULT_DRAIN_REQUANT_EN
    localparam logic signed [PARTIAL_SUM_BW-1:0] SAT_MAX = PARTIAL_SUM_BW'((64'sd1 <<< (DATA_BW - 1)) - 64'sd1);
    localparam logic signed [PARTIAL_SUM_BW-1:0] SAT_MIN = ~SAT_MAX;

    logic [SHIFT_W-1:0] r_shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shift <= '0;
        end else if (r_state == ST_IDLE && start) begin
            r_shift <= shift;
        end
    end

    for (genvar g = 0; g < MATRIX_SIZE; g++) begin : g_lane
        logic signed [PARTIAL_SUM_BW-1:0] w_lane;
        logic signed [PARTIAL_SUM_BW-1:0] w_shr;
        assign w_lane = w_head[g*PARTIAL_SUM_BW +: PARTIAL_SUM_BW];
        assign w_shr  = w_lane >>> r_shift;
        assign w_out[g*DATA_BW +: DATA_BW] = (w_shr > SAT_MAX) ? SAT_MAX[DATA_BW-1:0] :
                                             (w_shr < SAT_MIN) ? SAT_MIN[DATA_BW-1:0] :
                                                                 w_shr[DATA_BW-1:0];
    end
`else
    logic w_shift_unused;
    assign w_shift_unused = ^shift;
    assign w_out          = w_head;
`endif

    assign m_valid = w_valid;
    assign m_data  = w_valid ? w_out : '0;
    assign m_last  = w_valid & w_last_row;
endmodule

// File: tb/tb_result_drain_ctrl.sv
// Randomized and directed bench for result_drain_ctrl against a queue-based row/address model.
module tb_result_drain_ctrl;
    localparam int AW = 10;
    localparam int MS = 64;
    localparam int PB = 24;
    localparam int DB = 8;
`ifdef RESULT_DRAIN_REQUANT_EN
    localparam int OW = DB * MS;
`else
    localparam int OW = PB * MS;
`endif

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    base_addr = '0;
    logic [6:0]       num_rows = '0;
    logic [4:0]       shift = '0;
    logic             sram_re;
    logic [AW-1:0]    sram_addr;
    logic [PB*MS-1:0] sram_rdata = '0;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [OW-1:0]    m_data;
    logic             m_last;
    logic             busy;
    logic             done;

    result_drain_ctrl dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .base_addr  (base_addr),
        .num_rows   (num_rows),
        .shift      (shift),
        .sram_re    (sram_re),
        .sram_addr  (sram_addr),
        .sram_rdata (sram_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- SRAM model ----------------
    bit          ov_en = 1'b0;
    logic [PB-1:0] ov_val = '0;

    function automatic logic [PB*MS-1:0] row_of(input logic [AW-1:0] a);
        logic [PB*MS-1:0] r;
        for (int i = 0; i < MS; i++) begin
            r[i*PB +: PB] = ov_en ? ov_val : {a, 6'(i), a[7:0] ^ 8'h5A};
        end
        return r;
    endfunction

    always @(posedge clk) if (sram_re) sram_rdata <= row_of(sram_addr);

    function automatic logic [7:0] rq(input logic signed [PB-1:0] v, input logic [4:0] sh);
        int s;
        s = int'(v) >>> sh;
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
        return s[7:0];
    endfunction

    function automatic logic [OW-1:0] exp_out(input logic [AW-1:0] a, input logic [4:0] sh_unused_ok);
        logic [PB*MS-1:0] r;
        logic [OW-1:0]    o;
        r = row_of(a);
`ifdef RESULT_DRAIN_REQUANT_EN
        for (int i = 0; i < MS; i++) o[i*DB +: DB] = rq(r[i*PB +: PB], sh_unused_ok);
`else
        o = r;
`endif
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic chk_w(input string nm, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got low word %0h expected low word %0h (cycle %0d)", nm, act[63:0], exp[63:0], cyc);
        end
    endtask

    task automatic flag_fail(input string nm);
        checks++;
        fails++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // ---------------- behavioural model ----------------
    logic [AW-1:0] q_rd[$];
    logic [AW-1:0] q_row[$];
    logic [AW-1:0] seen_addr[$];
    bit            mdl_busy = 1'b0;
    bit            exp_done = 1'b0;
    bit            first_v  = 1'b0;
    bit            prev_hold = 1'b0;
    logic [OW-1:0] prev_data;
    logic          prev_last;
    logic [OW-1:0] last_data = '0;
    logic [4:0]    mdl_shift = '0;
    int            n_total = 0, n_reads = 0, n_xfer = 0, t_start = 0;
    int            n_done = 0, busy_cycles = 0;
    int            rmode = 0;

    always @(negedge clk) begin
        bit            nx_done;
        bit            nx_busy;
        logic [AW-1:0] ea;
        if (!rstn) begin
            chk("rst_outputs", {sram_re, |sram_addr, m_valid, |m_data, m_last, busy, done}, '0);
            q_rd.delete();
            q_row.delete();
            mdl_busy  = 1'b0;
            exp_done  = 1'b0;
            prev_hold = 1'b0;
            n_total = 0; n_reads = 0; n_xfer = 0;
        end else begin
            nx_done = 1'b0;
            nx_busy = mdl_busy;
            chk("done", done, exp_done);
            chk("busy", busy, mdl_busy);
            if (busy) busy_cycles++;
            if (exp_done) begin
                n_done++;
                nx_busy = 1'b0;
                chk("reads_total", n_reads, n_total);
                if (rmode == 0) chk("done_cycle", cyc, t_start + ((n_total == 0) ? 1 : n_total + 3));
            end
            if (sram_re) begin
                seen_addr.push_back(sram_addr);
                if (n_reads == 0) chk("first_re_cycle", cyc, t_start + 1);
                if (q_rd.size() == 0) flag_fail("unexpected_sram_re");
                else chk("sram_addr", sram_addr, q_rd.pop_front());
                n_reads++;
            end
            if (prev_hold) begin
                chk("hold_valid", m_valid, 1);
                chk_w("hold_data", m_data, prev_data);
                chk("hold_last", m_last, prev_last);
            end
            if (rmode == 0 && mdl_busy && !exp_done && n_xfer > 0 && n_xfer < n_total)
                chk("no_bubble", m_valid, 1);
            prev_hold = 1'b0;
            if (m_valid) begin
                if (!first_v) begin
                    chk("first_valid_cycle", cyc, t_start + 3);
                    first_v = 1'b1;
                end
                if (q_row.size() == 0) flag_fail("unexpected_m_valid");
                else begin
                    chk_w("m_data", m_data, exp_out(q_row[0], mdl_shift));
                    chk("m_last", m_last, (n_xfer == n_total - 1));
                    if (m_ready) begin
                        last_data = m_data;
                        void'(q_row.pop_front());
                        n_xfer++;
                        if (n_xfer == n_total) nx_done = 1'b1;
                    end else begin
                        prev_hold = 1'b1;
                        prev_data = m_data;
                        prev_last = m_last;
                    end
                end
            end
            chk("reads_ahead", (n_reads - n_xfer) <= 2, 1);
            if (start && !mdl_busy) begin
                t_start   = cyc;
                n_total   = int'(num_rows);
                mdl_shift = shift;
                n_reads = 0; n_xfer = 0;
                first_v = 1'b0;
                q_rd.delete();
                q_row.delete();
                for (int i = 0; i < int'(num_rows); i++) begin
                    ea = base_addr + AW'(i);
                    q_rd.push_back(ea);
                    q_row.push_back(ea);
                end
                nx_busy = 1'b1;
                if (num_rows == '0) nx_done = 1'b1;
            end
            exp_done = nx_done;
            mdl_busy = nx_busy;
        end
    end

    // ---------------- sink ready driver ----------------
    initial begin
        logic [3:0] pat;
        int         pidx;
        pat  = 4'b1001;
        pidx = 0;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: m_ready = 1'b1;
                1: begin m_ready = pat[3 - pidx]; pidx = (pidx + 1) % 4; end
                default: m_ready = ($urandom_range(0, 9) < 7);
            endcase
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_start(input logic [AW-1:0] b, input logic [6:0] n, input logic [4:0] s);
        @(posedge clk);
        #1;
        base_addr = b; num_rows = n; shift = s; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        base_addr = AW'($urandom);
        num_rows  = 7'($urandom_range(0, 64));
        shift     = 5'($urandom);
    endtask

    task automatic wait_idle(input string nm);
        int k;
        for (k = 0; k < 600; k++) begin
            @(posedge clk);
            if (!mdl_busy && !exp_done) break;
        end
        if (k >= 600) flag_fail({nm, "_timeout"});
    endtask

    initial begin
        int            d0;
        int            k;
        logic [AW-1:0] lit_addr [4];
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int            d0;
        int            k;
        logic [AW-1:0] lit_addr [4];
        lit_addr[0] = 10'd1022; lit_addr[1] = 10'd1023; lit_addr[2] = 10'd0; lit_addr[3] = 10'd1;

        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (2) @(posedge clk);

        // full-rate drain of 64 rows
        rmode = 0;
        d0 = n_done;
        do_start(10'd0, 7'd64, 5'd0);
        wait_idle("full64");
        chk("full64_done_count", n_done - d0, 1);

        // stalls: ready pattern 1,0,0,1
        rmode = 1;
        d0 = n_done;
        do_start(10'd5, 7'd4, 5'd3);
        wait_idle("stall4");
        chk("stall4_done_count", n_done - d0, 1);

        // address wrap
        rmode = 0;
        seen_addr.delete();
        do_start(10'd1022, 7'd4, 5'd0);
        wait_idle("wrap");
        chk("wrap_count", seen_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < seen_addr.size()) chk("wrap_addr", seen_addr[i], lit_addr[i]);
        end
`ifndef RESULT_DRAIN_REQUANT_EN
        chk("wrap_last_lane0", last_data[23:0], 24'h00405B);
`endif

        // zero rows
        busy_cycles = 0;
        seen_addr.delete();
        d0 = n_done;
        do_start(10'd77, 7'd0, 5'd0);
        wait_idle("zero");
        repeat (2) @(posedge clk);
        chk("zero_busy_cycles", busy_cycles, 1);
        chk("zero_reads", seen_addr.size(), 0);
        chk("zero_done_count", n_done - d0, 1);

        // start while busy is ignored
        d0 = n_done;
        do_start(10'd100, 7'd8, 5'd0);
        repeat (2) @(posedge clk);
        #1 base_addr = 10'd500; num_rows = 7'd2; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_idle("ignore");
        chk("ignore_done_count", n_done - d0, 1);

        // reset mid-drain
        d0 = n_done;
        do_start(10'd200, 7'd64, 5'd0);
        for (k = 0; k < 200; k++) begin
            @(posedge clk);
            if (n_xfer >= 10) break;
        end
        if (k >= 200) flag_fail("reset_wait_timeout");
        #1 rstn = 1'b0;
        #1;
        chk("rst_now_sram_re", sram_re, 0);
        chk("rst_now_sram_addr", sram_addr, 0);
        chk("rst_now_m_valid", m_valid, 0);
        chk("rst_now_m_data", |m_data, 0);
        chk("rst_now_m_last", m_last, 0);
        chk("rst_now_busy", busy, 0);
        chk("rst_now_done", done, 0);
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(posedge clk);
        chk("rst_no_done", n_done - d0, 0);
        do_start(10'd300, 7'd5, 5'd0);
        wait_idle("after_reset");
        chk("after_reset_done_count", n_done - d0, 1);

`ifdef RESULT_DRAIN_REQUANT_EN
        rmode = 0;
        ov_en = 1'b1;
        ov_val = 24'h001234;
        do_start(10'd7, 7'd1, 5'd4);
        wait_idle("rq_sat_hi");
        chk("rq_sat_hi", last_data[7:0], 8'h7F);
        ov_val = 24'hFFFED4;
        do_start(10'd7, 7'd1, 5'd1);
        wait_idle("rq_sat_lo");
        chk("rq_sat_lo", last_data[7:0], 8'h80);
        ov_val = 24'd200;
        do_start(10'd7, 7'd1, 5'd2);
        wait_idle("rq_pass");
        chk("rq_pass", last_data[7:0], 8'd50);
        ov_en = 1'b0;
`endif

        // randomized drains with random backpressure
        for (int it = 0; it < 12; it++) begin
            rmode = (it % 3 == 0) ? 0 : 2;
            d0 = n_done;
            do_start(AW'($urandom), 7'($urandom_range(0, 64)), 5'($urandom));
            wait_idle("random");
            chk("random_done_count", n_done - d0, 1);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
